// File: rtl/bram_arb_pkg.sv
// Shared types and defaults for the two-port block-RAM arbiter.
// Holds the arbiter state enum, the read return-tag enum and default sizes.
// Imported by bram_port_arbiter and bram_arb_starve_cnt.
package bram_arb_pkg;

  localparam int DEF_ADDR_WIDTH   = 12;
  localparam int DEF_STARVE_LIMIT = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GNT0   = 2'd1,
    ST_GNT1   = 2'd2,
    ST_FORCE1 = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    TAG_IDLE = 2'd0,
    TAG_M0   = 2'd1,
    TAG_M1   = 2'd2
  } ret_tag_e;

endpackage

// File: rtl/bram_arb_starve_cnt.sv
// Saturating count of consecutive cycles the display port was refused.
// Ports: HCLK/HRESETn, m1_req/m1_gnt from the arbiter; limit_next is high when
// the count reaches STARVE_LIMIT this edge while m1 is still asking.
module bram_arb_starve_cnt
  import bram_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic m1_req,
  input  logic m1_gnt,
  output logic limit_next
);

  localparam logic [7:0] LIMIT_C = 8'(STARVE_LIMIT);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!m1_req || m1_gnt) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT_C) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Looking at the next count lets the forced grant land right after the
  // last refused cycle, so a starved m1 waits exactly STARVE_LIMIT cycles.
  assign limit_next = m1_req && (cnt_d == LIMIT_C);

endmodule

// File: rtl/bram_port_arbiter.sv
// Arbitrates a CPU-bridge port (m0, read/write) and a display-fetch port (m1,
// read-only) onto one single-port block RAM with 1-cycle read latency.
// Ports: m0_* / m1_* request side, ram_* RAM side. Build option BRAM_ARB_RR_EN
// selects round-robin; otherwise fixed m0 priority with an m1 starvation guard.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  m0_req,
  input  logic [3:0]            m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [31:0]           m0_wdata,
  output logic                  m0_gnt,
  output logic [31:0]           m0_rdata,
  output logic                  m0_rvalid,
  input  logic                  m1_req,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  output logic                  m1_gnt,
  output logic [31:0]           m1_rdata,
  output logic                  m1_rvalid,
  output logic                  ram_en,
  output logic [3:0]            ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata
);

  arb_state_e  state_q, state_d;
  ret_tag_e    tag_q, tag_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;
  logic        force_next;

`ifdef BRAM_ARB_RR_EN
  // ptr_q=1 means m1 is preferred on a tie; reset gives m0 the first tie.
  logic ptr_q, ptr_d;
  assign force_next = 1'b0;
  assign ptr_d      = m1_gnt ? 1'b0 : (m0_gnt ? 1'b1 : ptr_q);
`else
  bram_arb_starve_cnt #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve_cnt (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .m1_req     (m1_req),
    .m1_gnt     (m1_gnt),
    .limit_next (force_next)
  );
`endif

  // Grants are gated by reset so nothing reaches the RAM while it is held.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (HRESETn) begin
`ifdef BRAM_ARB_RR_EN
      if (m0_req && m1_req) begin
        m1_gnt = ptr_q;
        m0_gnt = !ptr_q;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
`else
      if (state_q == ST_FORCE1 && m1_req) begin
        m1_gnt = 1'b1;
      end else if (m0_req) begin
        m0_gnt = 1'b1;
      end else if (m1_req) begin
        m1_gnt = 1'b1;
      end
`endif
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    if (force_next) begin
      state_d = ST_FORCE1;
    end else if (m0_gnt) begin
      state_d = ST_GNT0;
    end else if (m1_gnt) begin
      state_d = ST_GNT1;
    end
  end

  always_comb begin
    ram_en    = m0_gnt || m1_gnt;
    ram_we    = m0_gnt ? m0_we : 4'h0;
    ram_wdata = m0_gnt ? m0_wdata : 32'h0;
    ram_addr  = m1_gnt ? m1_addr : (m0_gnt ? m0_addr : '0);

    tag_d = TAG_IDLE;
    if (m0_gnt && m0_we == 4'h0) begin
      tag_d = TAG_M0;
    end else if (m1_gnt) begin
      tag_d = TAG_M1;
    end
  end

  // Read data passes straight through in the return cycle and is then held,
  // so the non-owner port keeps showing its last read.
  always_comb begin
    m0_rvalid  = (tag_q == TAG_M0);
    m1_rvalid  = (tag_q == TAG_M1);
    m0_rdata   = m0_rvalid ? ram_rdata : m0_rdata_q;
    m1_rdata   = m1_rvalid ? ram_rdata : m1_rdata_q;
    m0_rdata_d = m0_rdata;
    m1_rdata_d = m1_rdata;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= ST_IDLE;
      tag_q      <= TAG_IDLE;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
`ifdef BRAM_ARB_RR_EN
      ptr_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
`ifdef BRAM_ARB_RR_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter: directed scenarios followed by
// random traffic, compared against a behavioural arbiter/RAM model.
// A simple synchronous RAM model answers the DUT's ram_* port.
module tb_bram_port_arbiter;

  localparam int AW    = 12;
  localparam int LIMIT = 8;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          m0_req;
  logic [3:0]    m0_we;
  logic [AW-1:0] m0_addr;
  logic [31:0]   m0_wdata;
  logic          m0_gnt;
  logic [31:0]   m0_rdata;
  logic          m0_rvalid;
  logic          m1_req;
  logic [AW-1:0] m1_addr;
  logic          m1_gnt;
  logic [31:0]   m1_rdata;
  logic          m1_rvalid;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  bram_port_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rdata  (m0_rdata),
    .m0_rvalid (m0_rvalid),
    .m1_req    (m1_req),
    .m1_addr   (m1_addr),
    .m1_gnt    (m1_gnt),
    .m1_rdata  (m1_rdata),
    .m1_rvalid (m1_rvalid),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 HCLK = ~HCLK;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  logic [31:0] tbram [4096];
  logic [31:0] mmem  [4096];
  int          streak;
  bit          force_pend;
  bit          rr_ptr;
  int          pend_owner;   // 0 none, 1 m0, 2 m1
  logic [31:0] pend_data;
  logic [31:0] exp_r0, exp_r1;
  bit          auto_mode;
  bit          g0_obs, g1_obs, r0v_obs, r1v_obs;
  logic [31:0] r0_obs, r1_obs;

  function automatic logic [31:0] init_word(input int a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_m0(input logic req, input logic [3:0] we, input int addr, input logic [31:0] wd);
    m0_req = req; m0_we = we; m0_addr = AW'(addr); m0_wdata = wd;
  endtask

  task automatic set_m1(input logic req, input int addr);
    m1_req = req; m1_addr = AW'(addr);
  endtask

  task automatic new_m0();
    set_m0($urandom_range(0, 99) < 70,
           ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0,
           $urandom_range(0, 15), $urandom);
  endtask

  task automatic new_m1();
    set_m1($urandom_range(0, 99) < 60, $urandom_range(0, 15));
  endtask

  // One clock: check at the falling edge, then advance RAM, model and drivers.
  task automatic step();
    logic          e0, e1, b_en;
    logic [3:0]    b_we;
    logic [AW-1:0] b_addr;
    logic [31:0]   b_wd;
    @(negedge HCLK);
    if (!HRESETn) begin
      streak = 0; force_pend = 0; rr_ptr = 0; pend_owner = 0;
      exp_r0 = '0; exp_r1 = '0;
    end
    e0 = 1'b0; e1 = 1'b0;
    if (HRESETn) begin
`ifdef BRAM_ARB_RR_EN
      if (m0_req && m1_req) begin e1 = rr_ptr; e0 = !rr_ptr; end
      else begin e0 = m0_req; e1 = m1_req; end
`else
      if (force_pend && m1_req) e1 = 1'b1;
      else if (m0_req) e0 = 1'b1;
      else if (m1_req) e1 = 1'b1;
`endif
    end
    chk("m0_gnt", m0_gnt, e0);
    chk("m1_gnt", m1_gnt, e1);
    chk("ram_en", ram_en, e0 | e1);
    chk("ram_we", ram_we, e0 ? m0_we : 4'h0);
    if (e1) chk("ram_addr_m1", ram_addr, m1_addr);
    if (e0) chk("ram_addr_m0", ram_addr, m0_addr);
    if (e0 && m0_we != 4'h0) chk("ram_wdata", ram_wdata, m0_wdata);
    if (!HRESETn) begin
      chk("rst_ram_addr", ram_addr, '0);
      chk("rst_ram_wdata", ram_wdata, '0);
    end
    chk("m0_rvalid", m0_rvalid, pend_owner == 1);
    chk("m1_rvalid", m1_rvalid, pend_owner == 2);
    if (pend_owner == 1) exp_r0 = pend_data;
    if (pend_owner == 2) exp_r1 = pend_data;
    chk("m0_rdata", m0_rdata, exp_r0);
    chk("m1_rdata", m1_rdata, exp_r1);
    g0_obs = m0_gnt; g1_obs = m1_gnt;
    r0v_obs = m0_rvalid; r1v_obs = m1_rvalid;
    r0_obs = m0_rdata; r1_obs = m1_rdata;
    b_en = ram_en; b_we = ram_we; b_addr = ram_addr; b_wd = ram_wdata;

    @(posedge HCLK);
    #1;
    // RAM answering the DUT: data only meaningful after a read edge.
    if (b_en && b_we == 4'h0) ram_rdata = tbram[b_addr];
    else ram_rdata = $urandom;
    if (b_en) for (int b = 0; b < 4; b++)
      if (b_we[b]) tbram[b_addr][8*b +: 8] = b_wd[8*b +: 8];

    if (HRESETn) begin
      pend_owner = 0;
      if (e0) begin
        if (m0_we == 4'h0) begin
          pend_owner = 1; pend_data = mmem[m0_addr];
        end else begin
          for (int b = 0; b < 4; b++)
            if (m0_we[b]) mmem[m0_addr][8*b +: 8] = m0_wdata[8*b +: 8];
        end
      end
      if (e1) begin
        pend_owner = 2; pend_data = mmem[m1_addr];
      end
      if (m1_req && !e1) streak = (streak < LIMIT) ? streak + 1 : LIMIT;
      else streak = 0;
      force_pend = m1_req && (streak == LIMIT);
      if (e0) rr_ptr = 1'b1;
      if (e1) rr_ptr = 1'b0;
    end
    if (auto_mode) begin
      if (e0 || !m0_req) new_m0();
      if (e1 || !m1_req) new_m1();
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      tbram[i] = init_word(i);
      mmem[i]  = init_word(i);
    end
    auto_mode = 0;
    ram_rdata = '0;
    HRESETn   = 1'b0;
    set_m0(1'b1, 4'h0, 3, 32'h0);
    set_m1(1'b1, 4);
    // Requests during reset must be ignored and every output held at zero.
    for (int i = 0; i < 3; i++) step();
    set_m0(1'b0, 4'h0, 0, 32'h0);
    set_m1(1'b0, 0);
    HRESETn = 1'b1;
    step();

    // Write then read back the same word.
    set_m0(1'b1, 4'hF, 'h010, 32'hDEAD_BEEF);
    step();
    chk("s040_wr_gnt", g0_obs, 1'b1);
    set_m0(1'b1, 4'h0, 'h010, 32'h0);
    step();
    chk("s040_rd_gnt", g0_obs, 1'b1);
    set_m0(1'b0, 4'h0, 0, 32'h0);
    step();
    chk("s040_rvalid", r0v_obs, 1'b1);
    chk("s040_rdata", r0_obs, 32'hDEAD_BEEF);

    // m1 read followed by an m0 write to the neighbouring word.
    set_m1(1'b1, 'h020);
    step();
    set_m1(1'b0, 0);
    set_m0(1'b1, 4'hF, 'h021, 32'h1122_3344);
    step();
    chk("s043_m1_rvalid", r1v_obs, 1'b1);
    chk("s043_m0_rvalid", r0v_obs, 1'b0);
    chk("s043_m1_rdata", r1_obs, init_word('h020));
    set_m0(1'b0, 4'h0, 0, 32'h0);
    step();
    chk("s043_m1_hold", r1_obs, init_word('h020));

    // Both ports requesting continuously.
    set_m0(1'b1, 4'h0, 1, 32'h0);
    set_m1(1'b1, 2);
    for (int i = 0; i < 36; i++) begin
      bit prev1;
      prev1 = g1_obs;
      step();
`ifdef BRAM_ARB_RR_EN
      chk("s042_one_gnt", g0_obs ^ g1_obs, 1'b1);
      if (i > 0) chk("s042_alternate", g1_obs, !prev1);
`else
      chk("s041_m1_every9", g1_obs, (i % 9) == 8);
`endif
    end
    set_m0(1'b0, 4'h0, 0, 32'h0);
    set_m1(1'b0, 0);
    step();

`ifndef BRAM_ARB_RR_EN
    // m1 gives up exactly when its forced grant is due.
    set_m0(1'b1, 4'h0, 6, 32'h0);
    set_m1(1'b1, 7);
    for (int i = 0; i < LIMIT; i++) step();
    set_m1(1'b0, 0);
    step();
    chk("s045_m0_nostall", g0_obs, 1'b1);
    chk("s045_no_m1", g1_obs, 1'b0);
    // Counter must have restarted from zero: m1 waits a full LIMIT again.
    set_m1(1'b1, 7);
    for (int i = 0; i <= LIMIT; i++) begin
      step();
      chk("s045_restart", g1_obs, i == LIMIT);
    end
    set_m0(1'b0, 4'h0, 0, 32'h0);
    set_m1(1'b0, 0);
    step();
`endif

    // Reset pulse while a read is in flight.
    set_m0(1'b1, 4'h0, 5, 32'h0);
    step();
    chk("s044_rd_gnt", g0_obs, 1'b1);
    HRESETn = 1'b0;
    set_m1(1'b1, 9);
    step();
    chk("s044_no_rvalid", r0v_obs, 1'b0);
    chk("s044_rdata_zero", r0_obs, 32'h0);
    HRESETn = 1'b1;
    step();
    chk("s044_first_m0", g0_obs, 1'b1);
    set_m0(1'b0, 4'h0, 0, 32'h0);
    set_m1(1'b0, 0);
    step();

    // Random traffic.
    auto_mode = 1;
    new_m0();
    new_m1();
    for (int i = 0; i < 600; i++) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
